// File: rtl/demux2_sched_if.sv
// Four-phase control channel between the scheduler and the demux.
// rctl/dctl flow to the demux, actl returns from it.
interface demux2_sched_if;
   logic rctl_o;
   logic dctl_o;
   logic actl_i;

   modport master (
      output rctl_o,
      output dctl_o,
      input  actl_i
   );

   modport slave (
      input  rctl_o,
      input  dctl_o,
      output actl_i
   );
endinterface

// File: rtl/demux2_sched.sv
// Weighted round-robin control-token source for a two-way demux.
// Drives the four-phase rctl/dctl/actl channel and counts completed tokens.
module demux2_sched #(
   parameter int CW   = 4,
   parameter int CNTW = 16,
   parameter int SYNC = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_i,
   input  logic [CW-1:0]   w0_i,
   input  logic [CW-1:0]   w1_i,
   input  logic            skip0_i,
   input  logic            skip1_i,
   demux2_sched_if.master  ctl,
   output logic [CNTW-1:0] cnt0_o,
   output logic [CNTW-1:0] cnt1_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      REQ,
      RELEASE
   } state_t;

   state_t          state_q, state_d;
   logic            sel_q, sel_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic            rctl_q, rctl_d;
   logic            dctl_q, dctl_d;
   logic [CNTW-1:0] cnt0_q, cnt0_d;
   logic [CNTW-1:0] cnt1_q, cnt1_d;
   logic            busy_q;
   logic            ack;

   generate
      if (SYNC == 0) begin : g_nosync
         assign ack = ctl.actl_i;
      end else begin : g_sync
         logic [SYNC-1:0] sq;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sq <= '0;
            end else begin
               sq[0] <= ctl.actl_i;
               for (int i = 1; i < SYNC; i++)
                  sq[i] <= sq[i-1];
            end
         end
         assign ack = sq[SYNC-1];
      end
   endgenerate

   logic          elig0, elig1;
   logic          elig_cur, elig_oth;
   logic [CW-1:0] w_cur, w_oth;

   assign elig0    = (w0_i != '0) && !skip0_i;
   assign elig1    = (w1_i != '0) && !skip1_i;
   assign elig_cur = sel_q ? elig1 : elig0;
   assign elig_oth = sel_q ? elig0 : elig1;
   assign w_cur    = sel_q ? w1_i : w0_i;
   assign w_oth    = sel_q ? w0_i : w1_i;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rem_d   = rem_q;
      rctl_d  = rctl_q;
      dctl_d  = dctl_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      unique case (state_q)
         IDLE: begin
            rctl_d = 1'b0;
            if (en_i && !ack) begin
               // continue burst, then switch, then reload same side
               if (rem_q != '0 && elig_cur) begin
                  dctl_d  = sel_q;
                  state_d = SETUP;
               end else if (elig_oth) begin
                  sel_d   = ~sel_q;
                  rem_d   = w_oth;
                  dctl_d  = ~sel_q;
                  state_d = SETUP;
               end else if (elig_cur) begin
                  rem_d   = w_cur;
                  dctl_d  = sel_q;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            rctl_d  = 1'b1;
            state_d = REQ;
         end
         REQ: begin
            if (ack) begin
               rctl_d  = 1'b0;
               rem_d   = rem_q - 1'b1;
               if (sel_q)
                  cnt1_d = cnt1_q + 1'b1;
               else
                  cnt0_d = cnt0_q + 1'b1;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 1'b1;
         rem_q   <= '0;
         rctl_q  <= 1'b0;
         dctl_q  <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rem_q   <= rem_d;
         rctl_q  <= rctl_d;
         dctl_q  <= dctl_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign ctl.rctl_o = rctl_q;
   assign ctl.dctl_o = dctl_q;
   assign cnt0_o     = cnt0_q;
   assign cnt1_o     = cnt1_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_demux2_sched.sv
// Bench for demux2_sched: table of bursts plus hand-written corner sequences.
// Expected token sides are queued up front and popped on each rctl rise.
module tb_demux2_sched;

   logic clk;
   logic rst, rst_b;
   logic en, en_b;
   logic [3:0] w0, w1;
   logic skip0, skip1;
   logic [15:0] cnt0_a, cnt1_a;
   logic [3:0]  cnt0_b, cnt1_b;
   logic busy_a, busy_b;

   demux2_sched_if ifa ();
   demux2_sched_if ifb ();

   demux2_sched #(.CW(4), .CNTW(16), .SYNC(2)) u_a (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .w0_i    (w0),
      .w1_i    (w1),
      .skip0_i (skip0),
      .skip1_i (skip1),
      .ctl     (ifa.master),
      .cnt0_o  (cnt0_a),
      .cnt1_o  (cnt1_a),
      .busy_o  (busy_a)
   );

   demux2_sched #(.CW(4), .CNTW(4), .SYNC(0)) u_b (
      .clk     (clk),
      .rst     (rst_b),
      .en_i    (en_b),
      .w0_i    (4'd3),
      .w1_i    (4'd0),
      .skip0_i (1'b0),
      .skip1_i (1'b0),
      .ctl     (ifb.master),
      .cnt0_o  (cnt0_b),
      .cnt1_o  (cnt1_b),
      .busy_o  (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // acknowledger for DUT a: actl follows rctl after dly cycles
   logic [7:0] ack_sh;
   logic [8:0] ack_line;
   int         dly;
   logic       ack_force;

   always @(posedge clk or posedge rst) begin
      if (rst) ack_sh <= '0;
      else     ack_sh <= {ack_sh[6:0], ifa.rctl_o};
   end
   assign ack_line   = {ack_sh, ifa.rctl_o};
   assign ifa.actl_i = ack_force | ack_line[dly];
   assign ifb.actl_i = ifb.rctl_o;

   typedef struct {
      logic [3:0]  w0;
      logic [3:0]  w1;
      logic        s0;
      logic        s1;
      int          n;
      logic [15:0] seq;
      int          c0;
      int          c1;
   } vec_t;

   vec_t vecs[6];
   logic exp_q[$];
   int   checks, errors;
   int   tok, tok_b, base;
   logic prev_r, prev_b, in_hs, cur_d;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   task automatic wait_tok(input int target, input string nm);
      int k;
      k = 0;
      while (tok < target && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      chk(nm, tok, target);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy_a && k < 3000) begin
         @(negedge clk); #1;
         k++;
      end
      chk(nm, busy_a, 1'b0);
   endtask

   task automatic reset_a();
      en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; rst_b = 1'b1;
      en = 1'b0; en_b = 1'b0;
      w0 = 4'd0; w1 = 4'd0;
      skip0 = 1'b0; skip1 = 1'b0;
      dly = 0; ack_force = 1'b0;
      checks = 0; errors = 0;
      tok = 0; tok_b = 0;
      prev_r = 1'b0; prev_b = 1'b0;
      in_hs = 1'b0; cur_d = 1'b0;

      vecs[0] = '{4'd2, 4'd1, 1'b0, 1'b0, 6, 16'h0024, 4, 2};
      vecs[1] = '{4'd3, 4'd0, 1'b0, 1'b0, 7, 16'h0000, 7, 0};
      vecs[2] = '{4'd0, 4'd2, 1'b0, 1'b0, 4, 16'h000F, 0, 4};
      vecs[3] = '{4'd1, 4'd3, 1'b0, 1'b0, 8, 16'h00EE, 2, 6};
      vecs[4] = '{4'd0, 4'd0, 1'b0, 1'b0, 0, 16'h0000, 0, 0};
      vecs[5] = '{4'd2, 4'd2, 1'b0, 1'b1, 5, 16'h0000, 5, 0};

      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               prev_r = 1'b0;
               in_hs  = 1'b0;
            end else begin
               if (ifa.rctl_o && !prev_r) begin
                  tok++;
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL extra_token: dctl %0b, none expected",
                              ifa.dctl_o);
                  end else begin
                     chk("token_dctl", ifa.dctl_o, exp_q.pop_front());
                  end
                  in_hs = 1'b1;
                  cur_d = ifa.dctl_o;
               end else if (in_hs) begin
                  if (!busy_a) in_hs = 1'b0;
                  else chk("dctl_hold", ifa.dctl_o, cur_d);
               end
               prev_r = ifa.rctl_o;
            end
         end
         forever begin
            @(negedge clk);
            if (ifb.rctl_o && !prev_b) tok_b++;
            prev_b = ifb.rctl_o;
         end
      join_none

      // reset state
      @(negedge clk); #1;
      chk("rst_rctl", ifa.rctl_o, 1'b0);
      chk("rst_dctl", ifa.dctl_o, 1'b0);
      chk("rst_cnt0", cnt0_a, 16'd0);
      chk("rst_cnt1", cnt1_a, 16'd0);
      chk("rst_busy", busy_a, 1'b0);
      rst = 1'b0; rst_b = 1'b0;

      // SYNC=0 latency and CNTW=4 wrap
      @(negedge clk);
      en_b = 1'b1;
      @(posedge clk); #1;
      chk("b_lat1_busy", busy_b, 1'b1);
      chk("b_lat1_rctl", ifb.rctl_o, 1'b0);
      @(posedge clk); #1;
      chk("b_lat2_rctl", ifb.rctl_o, 1'b1);
      for (int k = 0; k < 3000 && tok_b < 17; k++) begin
         @(negedge clk); #1;
      end
      en_b = 1'b0;
      chk("b_tokens", tok_b, 17);
      for (int k = 0; k < 100 && busy_b; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("b_cnt0_wrap", cnt0_b, 4'd1);
      chk("b_cnt1", cnt1_b, 4'd0);

      // table of bursts, each from a fresh reset
      for (int v = 0; v < 6; v++) begin
         reset_a();
         w0 = vecs[v].w0; w1 = vecs[v].w1;
         skip0 = vecs[v].s0; skip1 = vecs[v].s1;
         for (int i = 0; i < vecs[v].n; i++)
            exp_q.push_back(vecs[v].seq[i]);
         base = tok;
         en = 1'b1;
         if (vecs[v].n == 0) begin
            repeat (20) @(negedge clk);
            #1;
            chk("none_busy", busy_a, 1'b0);
         end else begin
            wait_tok(base + vecs[v].n, "vec_tokens");
         end
         en = 1'b0;
         wait_idle("vec_idle");
         repeat (4) @(negedge clk);
         chk("vec_cnt0", cnt0_a, vecs[v].c0);
         chk("vec_cnt1", cnt1_a, vecs[v].c1);
         chk("vec_drain", exp_q.size(), 0);
      end
      skip1 = 1'b0;

      // skip0 mid-burst forces a switch, release resumes output 0
      reset_a();
      w0 = 4'd2; w1 = 4'd2;
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      base = tok;
      en = 1'b1;
      wait_tok(base + 1, "skip_t1");
      skip0 = 1'b1;
      wait_tok(base + 2, "skip_t2");
      skip0 = 1'b0;
      wait_tok(base + 5, "skip_t5");
      en = 1'b0;
      wait_idle("skip_idle");
      chk("skip_cnt0", cnt0_a, 16'd3);
      chk("skip_cnt1", cnt1_a, 16'd2);

      // slow acknowledger, en dropped while in REQ
      reset_a();
      dly = 5;
      w0 = 4'd1; w1 = 4'd1;
      exp_q.push_back(1'b0);
      base = tok;
      en = 1'b1;
      wait_tok(base + 1, "slow_t1");
      en = 1'b0;
      chk("slow_rctl_held", ifa.rctl_o, 1'b1);
      wait_idle("slow_idle");
      repeat (30) @(negedge clk);
      #1;
      chk("slow_rctl_low", ifa.rctl_o, 1'b0);
      chk("slow_actl_low", ifa.actl_i, 1'b0);
      chk("slow_no_more", tok, base + 1);
      chk("slow_cnt0", cnt0_a, 16'd1);

      // reset while rctl is high
      reset_a();
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      base = tok;
      en = 1'b1;
      wait_tok(base + 3, "mid_t3");
      chk("mid_rctl_pre", ifa.rctl_o, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rctl", ifa.rctl_o, 1'b0);
      chk("mid_dctl", ifa.dctl_o, 1'b0);
      chk("mid_cnt0", cnt0_a, 16'd0);
      chk("mid_cnt1", cnt1_a, 16'd0);
      chk("mid_busy", busy_a, 1'b0);
      @(negedge clk);
      exp_q.push_back(1'b0);
      base = tok;
      rst = 1'b0;
      wait_tok(base + 1, "mid_after");
      en = 1'b0;
      wait_idle("mid_idle");
      chk("mid_after_cnt0", cnt0_a, 16'd1);
      chk("mid_after_cnt1", cnt1_a, 16'd0);

      // ack already high in IDLE blocks decisions
      reset_a();
      dly = 0;
      ack_force = 1'b1;
      repeat (4) @(negedge clk);
      base = tok;
      en = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("ackhi_busy", busy_a, 1'b0);
      chk("ackhi_rctl", ifa.rctl_o, 1'b0);
      exp_q.push_back(1'b0);
      ack_force = 1'b0;
      wait_tok(base + 1, "ackhi_tok");
      en = 1'b0;
      wait_idle("ackhi_idle");
      chk("ackhi_cnt0", cnt0_a, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
